// File: rtl/dds_voice_ctrl.sv
// Four-voice DDS control block: byte frames on the command port set per-voice tuning,
// waveform and enable; a round-robin scanner selects enabled voices. Optional readback: DDS_CTRL_READBACK_EN.
module dds_voice_ctrl #(
    parameter int SCAN_DIV = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  cmd_data_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        err_clr_i,
    output logic [15:0] tune0_o,
    output logic [15:0] tune1_o,
    output logic [15:0] tune2_o,
    output logic [15:0] tune3_o,
    output logic [2:0]  sel0_o,
    output logic [2:0]  sel1_o,
    output logic [2:0]  sel2_o,
    output logic [2:0]  sel3_o,
    output logic [3:0]  voice_en_o,
    output logic [1:0]  scan_sel_o,
    output logic        scan_valid_o,
    output logic        err_o,
`ifdef DDS_CTRL_READBACK_EN
    output logic [7:0]  rsp_data_o,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
`endif
    output logic [2:0]  state_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HI     = 3'd1;
    localparam logic [2:0] S_LO     = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
`ifdef DDS_CTRL_READBACK_EN
    localparam logic [2:0] S_RD_HI  = 3'd4;
    localparam logic [2:0] S_RD_LO  = 3'd5;
`endif

    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0] SCAN_LAST = 8'(SCAN_DIV - 1);

    logic [2:0]  state_q, state_d;
    logic [1:0]  voice_q, voice_d;
    logic [2:0]  wave_q, wave_d;
    logic        en_q, en_d;
    logic [15:0] word_q, word_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        err_q, err_d;
    logic [7:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]  scan_sel_q, scan_sel_d;
    logic [15:0] tune_q [4];
    logic [2:0]  sel_q [4];
    logic [3:0]  voice_en_q;

    logic        accept;
    logic        hdr_bad;
    logic        err_set;
    logic        commit;
    logic        scan_found;
    logic [1:0]  scan_next;
    logic [1:0]  scan_cand;

    // Handshakes: a byte/response transfers on a rising edge where valid and ready are both
    // high; ready never depends on valid, and rsp_data stays stable while rsp_valid waits.
    assign cmd_ready_o = (state_q == S_IDLE) || (state_q == S_HI) || (state_q == S_LO);
    assign accept      = cmd_valid_i && cmd_ready_o;

`ifdef DDS_CTRL_READBACK_EN
    assign hdr_bad     = cmd_data_i[0];
    assign rsp_valid_o = (state_q == S_RD_HI) || (state_q == S_RD_LO);
    assign rsp_data_o  = (state_q == S_RD_LO) ? tune_q[voice_q][7:0] : tune_q[voice_q][15:8];
`else
    // Without readback a read request is just another malformed header.
    assign hdr_bad     = cmd_data_i[0] | cmd_data_i[1];
`endif

    always_comb begin
        state_d = state_q;
        voice_d = voice_q;
        wave_d  = wave_q;
        en_d    = en_q;
        word_d  = word_q;
        tmo_d   = tmo_q;
        err_set = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (accept) begin
                    if (hdr_bad) begin
                        err_set = 1'b1;
                    end else begin
                        voice_d = cmd_data_i[7:6];
                        wave_d  = cmd_data_i[5:3];
                        en_d    = cmd_data_i[2];
`ifdef DDS_CTRL_READBACK_EN
                        state_d = cmd_data_i[1] ? S_RD_HI : S_HI;
`else
                        state_d = S_HI;
`endif
                    end
                end
            end
            S_HI, S_LO: begin
                if (accept) begin
                    tmo_d = '0;
                    if (state_q == S_HI) begin
                        word_d[15:8] = cmd_data_i;
                        state_d      = S_LO;
                    end else begin
                        word_d[7:0] = cmd_data_i;
                        state_d     = S_COMMIT;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_COMMIT: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
`ifdef DDS_CTRL_READBACK_EN
            S_RD_HI: begin
                if (rsp_ready_i) state_d = S_RD_LO;
            end
            S_RD_LO: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // A new error in the same cycle as err_clr wins so no error is ever lost.
    assign err_d = (err_q & ~err_clr_i) | err_set;

    always_comb begin
        scan_found = 1'b0;
        scan_next  = scan_sel_q;
        scan_cand  = scan_sel_q;
        for (int k = 1; k <= 4; k++) begin
            scan_cand = scan_sel_q + 2'(k);
            if (!scan_found && voice_en_q[scan_cand]) begin
                scan_next  = scan_cand;
                scan_found = 1'b1;
            end
        end
    end

    assign scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? 8'd0 : scan_cnt_q + 8'd1;
    assign scan_sel_d = ((scan_cnt_q == SCAN_LAST) && scan_found) ? scan_next : scan_sel_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            voice_q    <= '0;
            wave_q     <= '0;
            en_q       <= 1'b0;
            word_q     <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            scan_cnt_q <= '0;
            scan_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            voice_q    <= voice_d;
            wave_q     <= wave_d;
            en_q       <= en_d;
            word_q     <= word_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            scan_cnt_q <= scan_cnt_d;
            scan_sel_q <= scan_sel_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                tune_q[i] <= '0;
                sel_q[i]  <= '0;
            end
            voice_en_q <= '0;
        end else if (commit) begin
            tune_q[voice_q]     <= word_q;
            sel_q[voice_q]      <= wave_q;
            voice_en_q[voice_q] <= en_q;
        end
    end

    assign tune0_o      = tune_q[0];
    assign tune1_o      = tune_q[1];
    assign tune2_o      = tune_q[2];
    assign tune3_o      = tune_q[3];
    assign sel0_o       = sel_q[0];
    assign sel1_o       = sel_q[1];
    assign sel2_o       = sel_q[2];
    assign sel3_o       = sel_q[3];
    assign voice_en_o   = voice_en_q;
    assign scan_sel_o   = scan_sel_q;
    assign scan_valid_o = voice_en_q[scan_sel_q];
    assign err_o        = err_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_dds_voice_ctrl.sv
// Bench for dds_voice_ctrl: frame table, directed corner sequences and random bytes checked
// every cycle against a queue-based frame model. Build with DDS_CTRL_READBACK_EN for readback.
module tb_dds_voice_ctrl;

    localparam int SCAN_DIV = 4;
    localparam int TIMEOUT  = 255;
`ifdef DDS_CTRL_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam logic [2:0] S_IDLE = 3'd0, S_HI = 3'd1, S_LO = 3'd2, S_COMMIT = 3'd3;
    localparam logic [2:0] S_RD_HI = 3'd4, S_RD_LO = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cmd_data = '0;
    logic        cmd_valid = 1'b0;
    logic        err_clr = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        cmd_ready;
    logic [15:0] tune0, tune1, tune2, tune3;
    logic [2:0]  sel0, sel1, sel2, sel3;
    logic [3:0]  voice_en;
    logic [1:0]  scan_sel;
    logic        scan_valid, err;
    logic [2:0]  state;
`ifdef DDS_CTRL_READBACK_EN
    logic [7:0]  rsp_data;
    logic        rsp_valid;
`endif

    dds_voice_ctrl #(.SCAN_DIV(SCAN_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_data_i(cmd_data), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .err_clr_i(err_clr),
        .tune0_o(tune0), .tune1_o(tune1), .tune2_o(tune2), .tune3_o(tune3),
        .sel0_o(sel0), .sel1_o(sel1), .sel2_o(sel2), .sel3_o(sel3),
        .voice_en_o(voice_en), .scan_sel_o(scan_sel), .scan_valid_o(scan_valid),
        .err_o(err),
`ifdef DDS_CTRL_READBACK_EN
        .rsp_data_o(rsp_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
`endif
        .state_o(state)
    );

    always #5 clk = ~clk;

    logic [15:0] d_tune [4];
    logic [2:0]  d_sel [4];
    assign d_tune[0] = tune0;
    assign d_tune[1] = tune1;
    assign d_tune[2] = tune2;
    assign d_tune[3] = tune3;
    assign d_sel[0]  = sel0;
    assign d_sel[1]  = sel1;
    assign d_sel[2]  = sel2;
    assign d_sel[3]  = sel3;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is the queue of bytes collected so far.
    logic [15:0] m_tune [4];
    logic [2:0]  m_sel [4];
    logic [3:0]  m_en;
    logic        m_err;
    logic [7:0]  m_frame [$];
    bit          m_commit;
    int          m_idle;
    int          m_ph;
    logic [1:0]  m_scan;
    int          m_rd;
    logic [1:0]  m_rd_v;

    function automatic bit m_ready();
        return !m_commit && (m_rd == 0);
    endfunction

    function automatic logic [2:0] m_state();
        if (m_commit) return S_COMMIT;
        if (m_rd == 1) return S_RD_HI;
        if (m_rd == 2) return S_RD_LO;
        if (m_frame.size() == 0) return S_IDLE;
        if (m_frame.size() == 1) return S_HI;
        return S_LO;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_tune[i] = '0;
            m_sel[i]  = '0;
        end
        m_en = '0; m_err = 1'b0; m_frame.delete(); m_commit = 1'b0;
        m_idle = 0; m_ph = 0; m_scan = '0; m_rd = 0; m_rd_v = '0;
    endtask

    task automatic model_step();
        bit          acc;
        bit          eset;
        logic [7:0]  hdr;
        int          v;
        acc  = cmd_valid && m_ready();
        eset = 1'b0;
        if (m_ph == SCAN_DIV - 1) begin
            for (int k = 1; k <= 4; k++) begin
                if (m_en[(m_scan + k) % 4]) begin
                    m_scan = 2'((m_scan + k) % 4);
                    break;
                end
            end
        end
        m_ph = (m_ph + 1) % SCAN_DIV;
        if (m_commit) begin
            hdr = m_frame[0];
            v   = int'(hdr[7:6]);
            m_tune[v] = {m_frame[1], m_frame[2]};
            m_sel[v]  = hdr[5:3];
            m_en[v]   = hdr[2];
            m_frame.delete();
            m_commit = 1'b0;
        end else if (m_rd != 0) begin
            if (rsp_ready) m_rd = (m_rd == 1) ? 2 : 0;
        end else if (acc) begin
            m_idle = 0;
            if (m_frame.size() == 0) begin
                if (cmd_data[0] || (cmd_data[1] && !RB)) eset = 1'b1;
                else if (cmd_data[1]) begin
                    m_rd = 1;
                    m_rd_v = cmd_data[7:6];
                end else m_frame.push_back(cmd_data);
            end else begin
                m_frame.push_back(cmd_data);
                if (m_frame.size() == 3) m_commit = 1'b1;
            end
        end else if (m_frame.size() != 0) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                eset = 1'b1;
                m_frame.delete();
                m_idle = 0;
            end
        end
        m_err = (m_err && !err_clr) || eset;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("m_cmd_ready", cmd_ready, m_ready());
            check("m_state", state, m_state());
            for (int i = 0; i < 4; i++) begin
                check($sformatf("m_tune%0d", i), d_tune[i], m_tune[i]);
                check($sformatf("m_sel%0d", i), d_sel[i], m_sel[i]);
            end
            check("m_voice_en", voice_en, m_en);
            check("m_scan_sel", scan_sel, m_scan);
            check("m_scan_valid", scan_valid, m_en[m_scan]);
            check("m_err", err, m_err);
`ifdef DDS_CTRL_READBACK_EN
            check("m_rsp_valid", rsp_valid, m_rd != 0);
            if (m_rd != 0)
                check("m_rsp_data", rsp_data, (m_rd == 2) ? m_tune[m_rd_v][7:0] : m_tune[m_rd_v][15:8]);
`endif
        end
    end

    // Drivers: called at a falling edge, return at the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b);
        bit acc;
        acc = 1'b0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        for (int n = 0; n < 64 && !acc; n++) begin
            acc = cmd_ready;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("send_accept", acc, 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] hi, input logic [7:0] lo);
        send_byte(h);
        send_byte(hi);
        send_byte(lo);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tune0"}, tune0, 16'h0);
        check({tag, "_tune1"}, tune1, 16'h0);
        check({tag, "_tune2"}, tune2, 16'h0);
        check({tag, "_tune3"}, tune3, 16'h0);
        check({tag, "_sels"}, {sel0, sel1, sel2, sel3}, 12'h0);
        check({tag, "_voice_en"}, voice_en, 4'h0);
        check({tag, "_scan_sel"}, scan_sel, 2'd0);
        check({tag, "_scan_valid"}, scan_valid, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_state"}, state, S_IDLE);
`ifdef DDS_CTRL_READBACK_EN
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
`endif
    endtask

    typedef struct {
        logic [7:0]  hdr;
        logic [7:0]  hi;
        logic [7:0]  lo;
        int          v;
        logic [15:0] tune;
        logic [2:0]  sel;
        logic        en;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [1:0] v0, v1, prev;
        bit         changed;
        logic [7:0] b;

        vecs[0] = '{8'h1C, 8'hBE, 8'hEF, 0, 16'hBEEF, 3'd3, 1'b1};
        vecs[1] = '{8'h6C, 8'h00, 8'h01, 1, 16'h0001, 3'd5, 1'b1};
        vecs[2] = '{8'hB8, 8'hFF, 8'hFF, 2, 16'hFFFF, 3'd7, 1'b0};
        vecs[3] = '{8'hE4, 8'h80, 8'h00, 3, 16'h8000, 3'd4, 1'b1};
        vecs[4] = '{8'h10, 8'h55, 8'hAA, 0, 16'h55AA, 3'd2, 1'b0};
        vecs[5] = '{8'hD0, 8'h12, 8'h34, 3, 16'h1234, 3'd2, 1'b0};

        repeat (3) @(negedge clk);
        #1 check_reset_values("rst_hold");
        check("rst_hold_cmd_ready", cmd_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1'b1);

        // Back-to-back frame to voice 1 with a single COMMIT bubble.
        send_byte(8'h44);
        send_byte(8'h12);
        send_byte(8'h34);
        check("f34_commit_ready", cmd_ready, 1'b0);
        check("f34_commit_state", state, S_COMMIT);
        check("f34_pre_tune1", tune1, 16'h0000);
        @(negedge clk);
        check("f34_ready_back", cmd_ready, 1'b1);
        check("f34_tune1", tune1, 16'h1234);
        check("f34_sel1", sel1, 3'd0);
        check("f34_voice_en", voice_en, 4'b0010);

        // Reserved-bit header, then clear; then clear colliding with a new error.
        send_byte(8'h01);
        check("hdr01_err", err, 1'b1);
        check("hdr01_state", state, S_IDLE);
        check("hdr01_tune1", tune1, 16'h1234);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr", err, 1'b0);
        send_byte(8'h01);
        err_clr = 1'b1;
        send_byte(8'h01);
        err_clr = 1'b0;
        check("clr_vs_new_err", err, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr2", err, 1'b0);
`ifndef DDS_CTRL_READBACK_EN
        send_byte(8'h42);
        check("rd_hdr_err", err, 1'b1);
        check("rd_hdr_state", state, S_IDLE);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
`endif

        // Header to voice 3 then silence until the timeout fires.
        send_byte(8'hC4);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("tmo_edge_err", err, 1'b0);
        check("tmo_edge_state", state, S_HI);
        @(negedge clk);
        check("tmo_err", err, 1'b1);
        check("tmo_state", state, S_IDLE);
        check("tmo_tune3", tune3, 16'h0000);
        check("tmo_voice_en", voice_en, 4'b0010);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // Scan alternates between voices 1 and 3.
        send_frame(8'hC4, 8'h00, 8'h10);
        check("scan_voice_en", voice_en, 4'b1010);
        prev = scan_sel;
        changed = 1'b0;
        for (int n = 0; n < 3 * SCAN_DIV && !changed; n++) begin
            @(negedge clk);
            changed = (scan_sel != prev);
        end
        check("scan_change_seen", changed, 1'b1);
        v0 = scan_sel;
        v1 = (v0 == 2'd1) ? 2'd3 : 2'd1;
        check("scan_first_enabled", (v0 == 2'd1) || (v0 == 2'd3), 1'b1);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < SCAN_DIV; c++) begin
                check($sformatf("scan_seq_r%0d_c%0d", r, c), scan_sel, (r % 2 == 0) ? v0 : v1);
                check("scan_seq_valid", scan_valid, 1'b1);
                @(negedge clk);
            end
        end

`ifdef DDS_CTRL_READBACK_EN
        // Read voice 1 with the response stalled for three cycles.
        rsp_ready = 1'b0;
        send_byte(8'h42);
        for (int n = 0; n < 3; n++) begin
            check("rd_hi_valid", rsp_valid, 1'b1);
            check("rd_hi_data", rsp_data, 8'h12);
            check("rd_hi_state", state, S_RD_HI);
            @(negedge clk);
        end
        check("rd_hi_data_last", rsp_data, 8'h12);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rd_lo_state", state, S_RD_LO);
        check("rd_lo_data", rsp_data, 8'h34);
        check("rd_lo_valid", rsp_valid, 1'b1);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rd_done_state", state, S_IDLE);
        check("rd_done_valid", rsp_valid, 1'b0);
`endif

        // Disable everything: scan freezes and reports invalid.
        send_frame(8'h40, 8'h12, 8'h34);
        send_frame(8'hC0, 8'h00, 8'h10);
        check("all_off_voice_en", voice_en, 4'b0000);
        prev = scan_sel;
        for (int n = 0; n < 3 * SCAN_DIV; n++) begin
            check("all_off_scan_valid", scan_valid, 1'b0);
            check("all_off_scan_hold", scan_sel, prev);
            @(negedge clk);
        end

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].hdr, vecs[i].hi, vecs[i].lo);
            check($sformatf("vec%0d_tune", i), d_tune[vecs[i].v], vecs[i].tune);
            check($sformatf("vec%0d_sel", i), d_sel[vecs[i].v], vecs[i].sel);
            check($sformatf("vec%0d_en", i), voice_en[vecs[i].v], vecs[i].en);
        end

        // Reset in the middle of a voice-2 frame, then a clean frame.
        send_byte(8'h94);
        send_byte(8'hAB);
        rst = 1'b1;
        #1 check_reset_values("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", cmd_ready, 1'b1);
        send_frame(8'h94, 8'hAB, 8'hCD);
        check("mid_rst_tune2", tune2, 16'hABCD);
        check("mid_rst_sel2", sel2, 3'd2);
        check("mid_rst_voice_en", voice_en, 4'b0100);

        for (int i = 0; i < 800; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 3) != 0) b[1:0] = 2'b00;
            cmd_data  = b;
            cmd_valid = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 19) == 0);
            rsp_ready = ($urandom_range(0, 1) == 1);
            if (i % 200 == 199) begin
                cmd_valid = 1'b0;
                err_clr   = 1'b0;
                repeat (TIMEOUT + 5) @(negedge clk);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        rsp_ready = 1'b1;
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dds_voice_ctrl.md
DDS_VOICE_CTRL -- requirements
Module: dds_voice_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 4; clock cycles each voice slot is held on the scan output, legal range 1..255.
REQ-002 Parameter TIMEOUT, default 255; idle cycles allowed between bytes inside a frame, legal range 1..255.
REQ-003 clk  in  1  single clock; all state is updated on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cmd_data  in  8  command byte.
REQ-006 cmd_valid  in  1  command byte valid.
REQ-007 cmd_ready  out  1  command byte accepted when valid and ready are both high on a clock edge.
REQ-008 err_clr  in  1  single-cycle pulse that clears err.
REQ-009 tune0..tune3  out  16 each  per-voice tuning word.
REQ-010 sel0..sel3  out  3 each  per-voice waveform select.
REQ-011 voice_en  out  4  per-voice enable mask.
REQ-012 scan_sel  out  2  voice currently routed to the output mux.
REQ-013 scan_valid  out  1  scan_sel points at an enabled voice.
REQ-014 err  out  1  sticky frame-error flag.
REQ-015 rsp_data  out  8 and rsp_valid  out  1 and rsp_ready  in  1; readback port, present only under DDS_CTRL_READBACK_EN.

Function
REQ-016 Header byte layout: [7:6] voice V, [5:3] wave, [2] enable, [1] rd, [0] reserved (must be 0).
REQ-017 FSM states IDLE, HI, LO, COMMIT, RD_HI, RD_LO; reset state is IDLE.
REQ-018 IDLE: accepted header with [0]=0 and rd=0 -> HI, header latched; [0]=1 -> err set, header discarded, stay IDLE.
REQ-019 HI: accepted byte latched as tune[15:8] -> LO; LO: accepted byte latched as tune[7:0] -> COMMIT.
REQ-020 COMMIT lasts one cycle with cmd_ready=0; tuneV, selV and voice_en[V] update together at the end of COMMIT -> IDLE.
REQ-021 Other voices are never disturbed by a frame; a partial frame leaves all outputs unchanged.
REQ-022 cmd_ready=1 in IDLE, HI and LO, and 0 in all other states.
REQ-023 Timeout counter resets on every accepted byte and counts only in HI/LO; reaching TIMEOUT -> err set, go to IDLE, latched bytes dropped.
REQ-024 Scan counter counts 0..SCAN_DIV-1; at wrap, scan_sel advances to the next enabled voice in round-robin order after the current one (it may return to the current voice).
REQ-025 When voice_en=0, scan_sel holds its value and scan_valid=0.
REQ-026 When the current voice becomes disabled, scan_valid drops the next cycle and the advance occurs at the next wrap.
REQ-027 err stays high until err_clr is pulsed; if err_clr and a new error occur in the same cycle, err=1.

Reset
REQ-028 While rst is high, the following values apply asynchronously: all tune=0x0000, all sel=0, voice_en=0, scan_sel=0, scan_valid=0, err=0, rsp_valid=0, FSM=IDLE, counters=0.
REQ-029 After rst deasserts, cmd_ready=1; rst asserted mid-frame discards the frame and leaves no partial update.

Configuration
REQ-030 With DDS_CTRL_READBACK_EN defined, a header with rd=1 -> RD_HI, which presents tuneV[15:8] on rsp_data with rsp_valid=1.
REQ-031 Under DDS_CTRL_READBACK_EN, RD_HI -> RD_LO on the rsp handshake, RD_LO presents tuneV[7:0], and the next handshake -> IDLE.
REQ-032 Under DDS_CTRL_READBACK_EN, rsp_data holds stable while rsp_ready is low, and the header's wave/enable bits are ignored for a read.
REQ-033 Without DDS_CTRL_READBACK_EN, the rsp ports and RD states are absent, and a header with rd=1 is treated as an error per REQ-018.

Verification
REQ-034 Bytes 0x44, 0x12, 0x34 back-to-back -> after COMMIT: tune1=0x1234, sel1=0, voice_en=0b0010, and cmd_ready low for exactly one cycle.
REQ-035 Header 0x01 -> err=1, no register change; then err_clr pulse -> err=0.
REQ-036 Header 0xC4 followed by 255 idle cycles (TIMEOUT=255) -> err=1, FSM back in IDLE, and tune3 unchanged.
REQ-037 With voice_en=0b1010 and SCAN_DIV=4 -> scan_sel sequence 1,3,1,3 with each value held 4 cycles; with voice_en=0 -> scan_valid=0.
REQ-038 rst pulsed after the HI byte of a frame to voice 2 -> all outputs at reset values, and a following full frame commits correctly.
REQ-039 With DDS_CTRL_READBACK_EN defined, after REQ-034 send header 0x42 and stall rsp_ready 3 cycles -> rsp_data holds 0x12 throughout, then 0x34, then FSM returns to IDLE.
